half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Bitwise half adder over WIDTH independent lanes. Per lane: sum = a XOR b, carry = a AND b.
- Provides a combinational result for immediate use.
- Also provides a one-cycle registered copy with a valid flag, plus a saturating carry-event counter.
- Leaf arithmetic primitive used by larger adders and by the team's training examples.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 8, width of the carry-event counter (>=1).

Ports:
- i_clk  input  1  single clock; all registers update on its rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_operando_a  input  WIDTH  operand A, one bit per lane.
- i_operando_b  input  WIDTH  operand B, one bit per lane.
- i_valid  input  1  qualifies operands for the registered path.
- o_suma  output  WIDTH  combinational sum: i_operando_a ^ i_operando_b.
- o_acarreo  output  WIDTH  combinational carry: i_operando_a & i_operando_b.
- o_suma_q  output  WIDTH  registered sum, captured when i_valid=1.
- o_acarreo_q  output  WIDTH  registered carry, captured when i_valid=1.
- o_valid  output  1  registered i_valid, aligned with o_suma_q / o_acarreo_q.
- o_cnt_acarreo  output  CNT_W  saturating count of accepted samples with any carry bit set.

Behaviour:
- Combinational path:
  - o_suma and o_acarreo are pure functions of the operands.
  - Zero latency; no dependence on i_clk or i_rst_n.
  - Valid even while reset is asserted.
- Lanes are fully independent. No carry propagates between lanes.
- Per lane, o_suma + 2*o_acarreo = a + b (range 0..2).
- Reset (i_rst_n=0, asynchronous):
  - o_suma_q = 0, o_acarreo_q = 0, o_valid = 0, o_cnt_acarreo = 0, immediately and held while low.
  - Deassertion takes effect at the first rising edge after i_rst_n goes high.
- Registered path, on a rising edge with i_rst_n=1:
  - o_valid <= i_valid.
  - If i_valid=1: o_suma_q <= a^b and o_acarreo_q <= a&b (latency 1 cycle).
  - If i_valid=0: o_suma_q and o_acarreo_q hold their previous values; o_valid drops to 0.
- Counter:
  - On an edge with i_valid=1 and any bit of (a&b) set: o_cnt_acarreo increments by 1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Otherwise it holds.
- Reset mid-operation clears all registered outputs and the counter at once. The combinational outputs are unaffected.
- X/undefined operands are not sanitised: the combinational outputs propagate them.
- No backpressure: every valid sample is accepted.

Test Plan:
- WIDTH=1, operand pairs a,b = 00, 01, 10, 11, each held 10 ns, no clock activity -> o_suma/o_acarreo = 0/0, 1/0, 1/0, 0/1.
- Reset: hold i_rst_n=0 while driving a=1, b=1, i_valid=1 -> registered outputs, o_valid and o_cnt_acarreo stay 0; o_suma=0 and o_acarreo=1 combinationally.
- After reset release:
  - Edge 1: a=1, b=1, i_valid=1 -> after that edge o_acarreo_q=1, o_suma_q=0, o_valid=1, o_cnt_acarreo=1.
  - Edge 2: i_valid=0 -> after that edge o_valid=0 and registered values hold.
- WIDTH=4, a=4'b1100, b=4'b1010, i_valid=1 -> o_suma=4'b0110 and o_acarreo=4'b1000 combinationally; identical registered values one cycle later.
- CNT_W=2, five consecutive valid samples with a=b=1 -> o_cnt_acarreo reads 1, 2, 3, 3, 3 (saturates, no wrap).
- Assert i_rst_n=0 asynchronously between clock edges while o_cnt_acarreo=3 -> counter and registered outputs become 0 before the next edge.

Source files
------------

// File: rtl/half_adder.sv
// Bitwise half adder over WIDTH independent lanes.
// Each lane computes sum = a ^ b and carry = a & b. No carry crosses between lanes.
// The block has three parts:
//   - A combinational result that works even while reset is asserted.
//   - A one-cycle registered copy of that result.
//   - A saturating counter of accepted samples whose carry vector is non-zero.
// Handshake: i_valid qualifies the operands on each rising edge. There is no ready,
// so every valid sample is accepted. o_valid is i_valid delayed by one cycle and
// marks the cycle in which o_suma_q / o_acarreo_q hold that sample's result.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_operando_a,
  input  logic [WIDTH-1:0] i_operando_b,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_suma,
  output logic [WIDTH-1:0] o_acarreo,
  output logic [WIDTH-1:0] o_suma_q,
  output logic [WIDTH-1:0] o_acarreo_q,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_cnt_acarreo
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] suma_c;
  logic [WIDTH-1:0] acarreo_c;

  logic [WIDTH-1:0] suma_q,    suma_d;
  logic [WIDTH-1:0] acarreo_q, acarreo_d;
  logic             valid_q,   valid_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Per-lane half-adder equations. X on an operand is passed straight through.
  assign suma_c    = i_operando_a ^ i_operando_b;
  assign acarreo_c = i_operando_a & i_operando_b;

  // Next-state logic: capture on valid, otherwise hold. The counter stops at all-ones.
  always_comb begin
    suma_d    = suma_q;
    acarreo_d = acarreo_q;
    valid_d   = i_valid;
    cnt_d     = cnt_q;
    if (i_valid) begin
      suma_d    = suma_c;
      acarreo_d = acarreo_c;
      if ((|acarreo_c) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers. Reset is asynchronous: a low i_rst_n clears them at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      suma_q    <= '0;
      acarreo_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      suma_q    <= suma_d;
      acarreo_q <= acarreo_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_suma        = suma_c;
  assign o_acarreo     = acarreo_c;
  assign o_suma_q      = suma_q;
  assign o_acarreo_q   = acarreo_q;
  assign o_valid       = valid_q;
  assign o_cnt_acarreo = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder. It runs two instances side by side:
//   - u_w1: WIDTH=1, CNT_W=2. Covers the directed single-lane and saturation steps.
//   - u_w4: WIDTH=4, CNT_W=8. Covers the multi-lane vector.
// Both instances then get randomized traffic, checked against an arithmetic lane model.
module tb_half_adder;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic clk_en = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 if (clk_en) i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT signals ----------------
  logic [0:0] a1, b1, s1, c1, sq1, cq1;
  logic       v1, ov1;
  logic [1:0] cnt1;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic       v4, ov4;
  logic [7:0] cnt4;

  half_adder #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_operando_a(a1), .i_operando_b(b1), .i_valid(v1),
    .o_suma(s1), .o_acarreo(c1), .o_suma_q(sq1), .o_acarreo_q(cq1),
    .o_valid(ov1), .o_cnt_acarreo(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_operando_a(a4), .i_operando_b(b4), .i_valid(v4),
    .o_suma(s4), .o_acarreo(c4), .o_suma_q(sq4), .o_acarreo_q(cq4),
    .o_valid(ov4), .o_cnt_acarreo(cnt4)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_sq1, m_cq1, m_sq4, m_cq4;
  logic       m_v1, m_v4;
  int         m_cnt1, m_cnt4;

  // Lane model: a lane adds two bits as integers (0..2).
  // The sum bit is the low bit of that total and the carry bit is the high bit.
  function automatic void ref_add(input logic [3:0] a, input logic [3:0] b,
                                  input int w, output logic [3:0] s, output logic [3:0] c);
    s = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < w) begin
        int t;
        t = int'(a[i]) + int'(b[i]);
        s[i] = (t % 2) == 1;
        c[i] = (t / 2) == 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sq1 = '0; m_cq1 = '0; m_v1 = 1'b0; m_cnt1 = 0;
    m_sq4 = '0; m_cq4 = '0; m_v4 = 1'b0; m_cnt4 = 0;
  endtask

  // Advance the model by one rising edge, using the inputs that are stable right now.
  task automatic model_edge();
    logic [3:0] s, c;
    if (!i_rst_n) begin
      model_clear();
    end else begin
      ref_add({3'b000, a1}, {3'b000, b1}, 1, s, c);
      m_v1 = v1;
      if (v1) begin
        m_sq1 = s;
        m_cq1 = c;
        if (c != 0) m_cnt1 = (m_cnt1 + 1 > 3) ? 3 : m_cnt1 + 1;
      end
      ref_add(a4, b4, 4, s, c);
      m_v4 = v4;
      if (v4) begin
        m_sq4 = s;
        m_cq4 = c;
        if (c != 0) m_cnt4 = (m_cnt4 + 1 > 255) ? 255 : m_cnt4 + 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] s, c;
    ref_add({3'b000, a1}, {3'b000, b1}, 1, s, c);
    chk({tag, "_w1_suma"},    32'(s1),  32'(s[0]));
    chk({tag, "_w1_acarreo"}, 32'(c1),  32'(c[0]));
    chk({tag, "_w1_suma_q"},  32'(sq1), 32'(m_sq1[0]));
    chk({tag, "_w1_acar_q"},  32'(cq1), 32'(m_cq1[0]));
    chk({tag, "_w1_valid"},   32'(ov1), 32'(m_v1));
    chk({tag, "_w1_cnt"},     32'(cnt1), 32'(m_cnt1));
    ref_add(a4, b4, 4, s, c);
    chk({tag, "_w4_suma"},    32'(s4),  32'(s));
    chk({tag, "_w4_acarreo"}, 32'(c4),  32'(c));
    chk({tag, "_w4_suma_q"},  32'(sq4), 32'(m_sq4));
    chk({tag, "_w4_acar_q"},  32'(cq4), 32'(m_cq4));
    chk({tag, "_w4_valid"},   32'(ov4), 32'(m_v4));
    chk({tag, "_w4_cnt"},     32'(cnt4), 32'(m_cnt4));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0] pat;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    model_clear();
    a1 = '0; b1 = '0; v1 = 1'b0;
    a4 = '0; b4 = '0; v4 = 1'b0;

    // Combinational truth table, clock stopped, reset held low.
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      a1 = pat[1];
      b1 = pat[0];
      #10;
      chk("tt_suma",    32'(s1), 32'((i == 1 || i == 2) ? 1 : 0));
      chk("tt_acarreo", 32'(c1), 32'((i == 3) ? 1 : 0));
    end

    // Reset held low with active operands: registers stay clear, comb path still works.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    clk_en = 1'b1;
    repeat (3) tick();
    chk("rst_suma_q",  32'(sq1), 32'(0));
    chk("rst_acar_q",  32'(cq1), 32'(0));
    chk("rst_valid",   32'(ov1), 32'(0));
    chk("rst_cnt",     32'(cnt1), 32'(0));
    chk("rst_suma",    32'(s1), 32'(0));
    chk("rst_acarreo", 32'(c1), 32'(1));
    check_all("rst");

    // Release reset between edges.
    i_rst_n = 1'b1;
    tick();
    chk("e1_acar_q", 32'(cq1), 32'(1));
    chk("e1_suma_q", 32'(sq1), 32'(0));
    chk("e1_valid",  32'(ov1), 32'(1));
    chk("e1_cnt",    32'(cnt1), 32'(1));
    v1 = 1'b0;
    tick();
    chk("e2_valid",  32'(ov1), 32'(0));
    chk("e2_acar_q", 32'(cq1), 32'(1));
    chk("e2_suma_q", 32'(sq1), 32'(0));
    chk("e2_cnt",    32'(cnt1), 32'(1));

    // Short asynchronous reset pulse, then a saturation run on the 2-bit counter.
    #2 i_rst_n = 1'b0;
    #1 i_rst_n = 1'b1;
    model_clear();
    v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(cnt1), 32'(exp_cnt[k]));
    end

    // Reset asserted mid-cycle clears everything before the next edge.
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_cnt",    32'(cnt1), 32'(0));
    chk("async_acar_q", 32'(cq1), 32'(0));
    chk("async_valid",  32'(ov1), 32'(0));
    chk("async_acarreo", 32'(c1), 32'(1));
    model_clear();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    v1 = 1'b0;

    // Four-lane directed vector.
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    #1;
    chk("w4_suma",    32'(s4), 32'(4'b0110));
    chk("w4_acarreo", 32'(c4), 32'(4'b1000));
    tick();
    chk("w4_suma_q",  32'(sq4), 32'(4'b0110));
    chk("w4_acar_q",  32'(cq4), 32'(4'b1000));
    chk("w4_valid",   32'(ov4), 32'(1));
    check_all("w4");

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      v4 = 1'($urandom_range(0, 1));
      tick();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
